// File: rtl/grey_threshold_if.sv
// Pixel-stream bundle between the histogram-side source and the grey_threshold stage.
// The slave view belongs to the stage itself; the master view drives the pixels and reads results.
interface grey_threshold_if #(
  parameter int COUNT_W = 20
);
  logic [11:0]        iGrey;
  logic               iDval;
  logic               iFval;
  logic [15:0]        iX_Cont;
  logic [15:0]        iY_Cont;
  logic [7:0]         iThresh;
  logic [1:0]         iMode;
  logic [11:0]        oGrey;
  logic               oDval;
  logic               oFval;
  logic [15:0]        oX_Cont;
  logic [15:0]        oY_Cont;
  logic [7:0]         oThreshLatched;
  logic [COUNT_W-1:0] oAboveCount;
  logic               oCountValid;
  logic [1:0]         oState;

  modport slave (
    input  iGrey, iDval, iFval, iX_Cont, iY_Cont, iThresh, iMode,
    output oGrey, oDval, oFval, oX_Cont, oY_Cont, oThreshLatched,
           oAboveCount, oCountValid, oState
  );

  modport master (
    output iGrey, iDval, iFval, iX_Cont, iY_Cont, iThresh, iMode,
    input  oGrey, oDval, oFval, oX_Cont, oY_Cont, oThreshLatched,
           oAboveCount, oCountValid, oState
  );
endinterface

// File: rtl/grey_threshold.sv
// Per-frame threshold stage: latches threshold/mode at frame start, maps pixels through a
// 2-stage pipeline (pass / binarise / inverse / stretch) and publishes an above-threshold count.
module grey_threshold #(
  parameter int COUNT_W       = 20,
  parameter int STRETCH_SHIFT = 1
) (
  input  logic             iPclk,
  input  logic             iRST_N,
  grey_threshold_if.slave  bus
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_FRAME   = 2'd2;
  localparam logic [1:0] S_PUBLISH = 2'd3;

  logic [1:0]         state_reg, state_next;
  logic               fval_prev_reg;
  logic [7:0]         thr_reg;
  logic [1:0]         mode_reg;
  logic [COUNT_W-1:0] count_reg;
  logic [COUNT_W-1:0] count_out_reg;
  logic               count_valid_reg;

  logic               rise, fall, latch;
  logic [7:0]         thr_eff;
  logic [1:0]         mode_eff;
  logic               ge, count_en;

  // Stage 1 carries the per-pixel threshold/mode so a frame change never tears a pixel.
  logic [11:0] s1_grey_reg;
  logic        s1_dval_reg, s1_fval_reg, s1_ge_reg;
  logic [15:0] s1_x_reg, s1_y_reg;
  logic [7:0]  s1_thr_reg;
  logic [1:0]  s1_mode_reg;

  logic [11:0] s2_grey_reg, grey_next;
  logic        s2_dval_reg, s2_fval_reg;
  logic [15:0] s2_x_reg, s2_y_reg;

  logic [12:0] diff;
  logic [14:0] shifted;
  logic [11:0] stretch;

  assign rise = bus.iFval & ~fval_prev_reg;
  assign fall = ~bus.iFval & fval_prev_reg;

  always_comb begin
    state_next = state_reg;
    latch      = 1'b0;
    case (state_reg)
      S_IDLE:    if (!bus.iFval) state_next = S_ARMED;
      S_ARMED:   if (rise) begin latch = 1'b1; state_next = S_FRAME; end
      S_FRAME:   if (fall) state_next = S_PUBLISH;
      S_PUBLISH: begin
        if (rise) begin
          latch      = 1'b1;
          state_next = S_FRAME;
        end else begin
          state_next = S_ARMED;
        end
      end
      default:   state_next = S_IDLE;
    endcase
  end

  // On the latch cycle the fresh threshold applies to the pixel arriving with the rising edge.
  assign thr_eff  = latch ? bus.iThresh : thr_reg;
  assign mode_eff = latch ? bus.iMode   : mode_reg;
  assign ge       = (bus.iGrey[11:4] >= thr_eff);
  assign count_en = bus.iDval & ge & bus.iFval & (latch | (state_reg == S_FRAME));

  always_ff @(posedge iPclk or negedge iRST_N) begin
    if (!iRST_N) begin
      state_reg       <= S_IDLE;
      fval_prev_reg   <= 1'b0;
      thr_reg         <= '0;
      mode_reg        <= '0;
      count_reg       <= '0;
      count_out_reg   <= '0;
      count_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      fval_prev_reg   <= bus.iFval;
      count_valid_reg <= (state_next == S_PUBLISH);
      if (latch) begin
        thr_reg   <= bus.iThresh;
        mode_reg  <= bus.iMode;
        count_reg <= count_en ? COUNT_W'(1) : '0;
      end else if (count_en && (count_reg != {COUNT_W{1'b1}})) begin
        count_reg <= count_reg + 1'b1;
      end
      if (state_reg == S_FRAME && fall) count_out_reg <= count_reg;
    end
  end

  always_ff @(posedge iPclk or negedge iRST_N) begin
    if (!iRST_N) begin
      s1_grey_reg <= '0;
      s1_dval_reg <= 1'b0;
      s1_fval_reg <= 1'b0;
      s1_ge_reg   <= 1'b0;
      s1_x_reg    <= '0;
      s1_y_reg    <= '0;
      s1_thr_reg  <= '0;
      s1_mode_reg <= '0;
      s2_grey_reg <= '0;
      s2_dval_reg <= 1'b0;
      s2_fval_reg <= 1'b0;
      s2_x_reg    <= '0;
      s2_y_reg    <= '0;
    end else begin
      s1_grey_reg <= bus.iGrey;
      s1_dval_reg <= bus.iDval & (state_reg != S_IDLE);
      s1_fval_reg <= bus.iFval;
      s1_ge_reg   <= ge;
      s1_x_reg    <= bus.iX_Cont;
      s1_y_reg    <= bus.iY_Cont;
      s1_thr_reg  <= thr_eff;
      s1_mode_reg <= mode_eff;
      s2_grey_reg <= grey_next;
      s2_dval_reg <= s1_dval_reg;
      s2_fval_reg <= s1_fval_reg;
      s2_x_reg    <= s1_x_reg;
      s2_y_reg    <= s1_y_reg;
    end
  end

  // Stretch: 13-bit signed difference, clamp negatives, then shift with saturation.
  assign diff    = {1'b0, s1_grey_reg} - {1'b0, s1_thr_reg, 4'b0000};
  assign shifted = {3'b000, diff[11:0]} << STRETCH_SHIFT;
  assign stretch = diff[12] ? 12'h000 : ((|shifted[14:12]) ? 12'hFFF : shifted[11:0]);

  always_comb begin
    grey_next = 12'h000;
    if (s1_dval_reg) begin
      case (s1_mode_reg)
        2'd0:    grey_next = s1_grey_reg;
        2'd1:    grey_next = s1_ge_reg ? 12'hFFF : 12'h000;
        2'd2:    grey_next = s1_ge_reg ? 12'h000 : 12'hFFF;
        default: grey_next = stretch;
      endcase
    end
  end

  assign bus.oGrey          = s2_grey_reg;
  assign bus.oDval          = s2_dval_reg;
  assign bus.oFval          = s2_fval_reg;
  assign bus.oX_Cont        = s2_x_reg;
  assign bus.oY_Cont        = s2_y_reg;
  assign bus.oThreshLatched = thr_reg;
  assign bus.oAboveCount    = count_out_reg;
  assign bus.oCountValid    = count_valid_reg;
  assign bus.oState         = state_reg;
endmodule
